// File: rtl/obu_parse_scheduler.sv
// Hands the bitstream FIFO to one sub-parser at a time: OBU header, then sequence/frame header or a skip.
// Latency: grant/in_pop/sub_avail are combinational; sub_start is registered and pulses in the first cycle of ownership.
// Backpressure: in_pop is asserted only for the granted parser's pop (or a skip pop) while in_valid is high; otherwise the FIFO stalls.
module obu_parse_scheduler #(
    parameter int PARSER_DATA_WIDTH = 32,
    parameter int MAX_OBU_WORDS     = 65535
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [PARSER_DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_pop,
    output logic [PARSER_DATA_WIDTH-1:0] sub_data,
    output logic [2:0]                   grant,
    output logic [2:0]                   sub_avail,
    input  logic [2:0]                   sub_pop,
    output logic [2:0]                   sub_start,
    input  logic [2:0]                   sub_done,
    input  logic [3:0]                   hdr_obu_type,
    input  logic [31:0]                  hdr_obu_words,
    output logic                         busy,
    output logic                         err,
    output logic [15:0]                  obu_count
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DISPATCH,
        SEQ,
        FRM,
        SKIP,
        ERR
    } state_t;

    localparam logic [31:0] MAX_WORDS = 32'(MAX_OBU_WORDS);

    state_t      state;
    logic [3:0]  obu_type_q;
    logic [31:0] obu_words_q;
    logic [31:0] skip_cnt;
    logic [15:0] obu_cnt_q;
    logic        err_q;
    logic        foreign_done;
    logic        obu_done;

    always_comb begin
        grant = 3'b000;
        case (state)
            HDR:     grant = 3'b001;
            SEQ:     grant = 3'b010;
            FRM:     grant = 3'b100;
            default: grant = 3'b000;
        endcase
        if (rst) begin
            grant = 3'b000;
        end
    end

    assign sub_avail = grant & {3{in_valid}};
    assign sub_data  = in_data;

    always_comb begin
        in_pop = 1'b0;
        case (state)
            HDR, SEQ, FRM: in_pop = in_valid & (|(sub_pop & grant));
            SKIP:          in_pop = in_valid & (skip_cnt != 32'd0);
            default:       in_pop = 1'b0;
        endcase
        if (rst) begin
            in_pop = 1'b0;
        end
    end

    // A done pulse from any parser that does not own the stream is a protocol violation.
    assign foreign_done = |(sub_done & ~grant);

    always_comb begin
        obu_done = 1'b0;
        if (!foreign_done) begin
            case (state)
                DISPATCH: obu_done = (obu_words_q == 32'd0);
                SEQ:      obu_done = sub_done[1];
                FRM:      obu_done = sub_done[2];
                SKIP:     obu_done = in_pop & (skip_cnt == 32'd1);
                default:  obu_done = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sub_start   <= 3'b000;
            err_q       <= 1'b0;
            obu_cnt_q   <= 16'd0;
            skip_cnt    <= 32'd0;
            obu_type_q  <= 4'd0;
            obu_words_q <= 32'd0;
        end else begin
            sub_start <= 3'b000;
            obu_cnt_q <= obu_cnt_q + 16'(obu_done);
            if (state != ERR && foreign_done) begin
                state <= ERR;
                err_q <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (enable) begin
                            sub_start <= 3'b001;
                            state     <= HDR;
                        end
                    end
                    HDR: begin
                        if (sub_done[0]) begin
                            obu_type_q  <= hdr_obu_type;
                            obu_words_q <= hdr_obu_words;
                            state       <= DISPATCH;
                        end
                    end
                    DISPATCH: begin
                        if (obu_words_q > MAX_WORDS) begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end else if (obu_words_q == 32'd0) begin
                            state <= IDLE;
                        end else if (obu_type_q == 4'd1) begin
                            sub_start <= 3'b010;
                            state     <= SEQ;
                        end else if (obu_type_q == 4'd3 || obu_type_q == 4'd6) begin
                            sub_start <= 3'b100;
                            state     <= FRM;
                        end else begin
                            skip_cnt <= obu_words_q;
                            state    <= SKIP;
                        end
                    end
                    SEQ: begin
                        if (sub_done[1]) begin
                            state <= IDLE;
                        end
                    end
                    FRM: begin
                        if (sub_done[2]) begin
                            state <= IDLE;
                        end
                    end
                    SKIP: begin
                        if (in_pop) begin
                            skip_cnt <= skip_cnt - 32'd1;
                            if (skip_cnt == 32'd1) begin
                                state <= IDLE;
                            end
                        end
                    end
                    ERR:     state <= ERR;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy      = (state != IDLE);
    assign err       = err_q;
    assign obu_count = obu_cnt_q;

endmodule

// File: tb/tb_obu_parse_scheduler.sv
// Directed bench for obu_parse_scheduler with a transaction-level reference model checked every cycle.
module tb_obu_parse_scheduler;

    localparam int W    = 32;
    localparam int MAXW = 65535;

    localparam int M_IDLE  = 0;
    localparam int M_PARSE = 1;
    localparam int M_DISP  = 2;
    localparam int M_SKIP  = 3;
    localparam int M_ERR   = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_pop;
    logic [W-1:0] sub_data;
    logic [2:0]   grant;
    logic [2:0]   sub_avail;
    logic [2:0]   sub_pop = 3'b000;
    logic [2:0]   sub_start;
    logic [2:0]   sub_done = 3'b000;
    logic [3:0]   hdr_obu_type = 4'd0;
    logic [31:0]  hdr_obu_words = 32'd0;
    logic         busy;
    logic         err;
    logic [15:0]  obu_count;

    always #5 clk = ~clk;

    obu_parse_scheduler #(
        .PARSER_DATA_WIDTH(W),
        .MAX_OBU_WORDS(MAXW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_pop(in_pop),
        .sub_data(sub_data),
        .grant(grant),
        .sub_avail(sub_avail),
        .sub_pop(sub_pop),
        .sub_start(sub_start),
        .sub_done(sub_done),
        .hdr_obu_type(hdr_obu_type),
        .hdr_obu_words(hdr_obu_words),
        .busy(busy),
        .err(err),
        .obu_count(obu_count)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the stream, how many skip words remain, how many OBUs finished.
    int          m_mode  = M_IDLE;
    int          m_owner = 0;
    logic [3:0]  m_type  = 4'd0;
    logic [31:0] m_words = 32'd0;
    logic [31:0] m_skip  = 32'd0;
    logic [2:0]  m_start = 3'b000;
    logic        m_err   = 1'b0;
    logic [15:0] m_count = 16'd0;

    function automatic logic [2:0] m_grant();
        if (rst || m_mode != M_PARSE) return 3'b000;
        return 3'(1 << m_owner);
    endfunction

    function automatic logic m_pop();
        if (rst) return 1'b0;
        if (m_mode == M_PARSE) return in_valid && ((sub_pop & m_grant()) != 3'b000);
        if (m_mode == M_SKIP) return in_valid && (m_skip != 32'd0);
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        logic [2:0] g;
        logic       p;
        logic [2:0] ns;
        g  = m_grant();
        p  = m_pop();
        ns = 3'b000;
        if (rst) begin
            m_mode = M_IDLE; m_owner = 0; m_type = 4'd0; m_words = 32'd0;
            m_skip = 32'd0; m_err = 1'b0; m_count = 16'd0;
        end else if (m_mode != M_ERR && (sub_done & ~g) != 3'b000) begin
            m_mode = M_ERR;
            m_err  = 1'b1;
        end else begin
            case (m_mode)
                M_IDLE: if (enable) begin
                    m_mode = M_PARSE; m_owner = 0; ns = 3'b001;
                end
                M_PARSE: if (sub_done[m_owner]) begin
                    if (m_owner == 0) begin
                        m_type = hdr_obu_type; m_words = hdr_obu_words; m_mode = M_DISP;
                    end else begin
                        m_count++; m_mode = M_IDLE;
                    end
                end
                M_DISP: begin
                    if (m_words > 32'(MAXW)) begin
                        m_mode = M_ERR; m_err = 1'b1;
                    end else if (m_words == 32'd0) begin
                        m_count++; m_mode = M_IDLE;
                    end else if (m_type == 4'd1) begin
                        m_owner = 1; ns = 3'b010; m_mode = M_PARSE;
                    end else if (m_type == 4'd3 || m_type == 4'd6) begin
                        m_owner = 2; ns = 3'b100; m_mode = M_PARSE;
                    end else begin
                        m_skip = m_words; m_mode = M_SKIP;
                    end
                end
                M_SKIP: if (p) begin
                    m_skip--;
                    if (m_skip == 32'd0) begin
                        m_count++; m_mode = M_IDLE;
                    end
                end
                default: ;
            endcase
        end
        m_start = ns;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("grant", 32'(grant), 32'(m_grant()));
            check("in_pop", 32'(in_pop), 32'(m_pop()));
            check("sub_avail", 32'(sub_avail), 32'(m_grant() & {3{in_valid}}));
            check("sub_start", 32'(sub_start), 32'(m_start));
            check("busy", 32'(busy), 32'(m_mode != M_IDLE));
            check("err", 32'(err), 32'(m_err));
            check("obu_count", 32'(obu_count), 32'(m_count));
            check("sub_data", sub_data, in_data);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_obu();
        enable = 1'b1;
        cyc(1);
        enable = 1'b0;
    endtask

    // Pops npop header words, signals header done, then steps through DISPATCH.
    task automatic hdr_done(input logic [3:0] t, input logic [31:0] w, input int npop);
        sub_pop  = 3'b001;
        in_valid = 1'b1;
        cyc(npop);
        sub_pop       = 3'b000;
        hdr_obu_type  = t;
        hdr_obu_words = w;
        sub_done      = 3'b001;
        cyc(1);
        sub_done = 3'b000;
        cyc(1);
    endtask

    initial begin
        int n;
        bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

        in_valid = 1'b1;
        in_data  = 32'hA5A5_0001;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_count", 32'(obu_count), 0);
        check("rst_in_pop", 32'(in_pop), 0);
        cyc(1);
        check("post_rst_in_pop", 32'(in_pop), 0);

        // Sequence header OBU
        in_data = 32'h1234_5678;
        start_obu();
        check("hdr_start", 32'(sub_start), 1);
        check("hdr_grant", 32'(grant), 1);
        hdr_done(4'd1, 32'd4, 2);
        check("seq_start", 32'(sub_start), 2);
        check("seq_grant", 32'(grant), 2);
        sub_pop = 3'b110;
        cyc(2);
        in_valid = 1'b0;
        sub_pop  = 3'b010;
        #1;
        check("seq_stall", 32'(in_pop), 0);
        cyc(1);
        in_valid = 1'b1;
        sub_done = 3'b010;
        cyc(1);
        sub_done = 3'b000;
        sub_pop  = 3'b000;
        check("seq_count", 32'(obu_count), 1);
        check("seq_idle", 32'(busy), 0);

        // Skipped OBU with a gap in in_valid
        in_data = 32'hDEAD_BEEF;
        start_obu();
        hdr_done(4'd15, 32'd3, 1);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = pat[i];
            #1;
            if (in_pop) n++;
            cyc(1);
        end
        check("skip_pops", 32'(n), 3);
        check("skip_idle", 32'(busy), 0);
        check("skip_count", 32'(obu_count), 2);

        // Zero-length frame OBU completes straight from DISPATCH
        start_obu();
        hdr_done(4'd3, 32'd0, 0);
        check("zero_idle", 32'(busy), 0);
        check("zero_count", 32'(obu_count), 3);
        check("zero_no_start", 32'(sub_start), 0);

        // Frame header with pop coincident with done
        start_obu();
        hdr_done(4'd6, 32'd2, 0);
        check("frm_start", 32'(sub_start), 4);
        check("frm_grant", 32'(grant), 4);
        in_valid = 1'b1;
        sub_pop  = 3'b101;
        cyc(1);
        sub_pop  = 3'b100;
        sub_done = 3'b100;
        #1;
        check("frm_coinc_pop", 32'(in_pop), 1);
        cyc(1);
        sub_pop  = 3'b000;
        sub_done = 3'b000;
        check("frm_count", 32'(obu_count), 4);
        check("frm_idle", 32'(busy), 0);

        // Reset in the middle of a skip with five words left
        start_obu();
        hdr_done(4'd15, 32'd8, 0);
        in_valid = 1'b1;
        cyc(3);
        check("skip5_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("rst_mid_pop", 32'(in_pop), 0);
        cyc(1);
        rst = 1'b0;
        check("rst_mid_grant", 32'(grant), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_count", 32'(obu_count), 0);
        check("rst_mid_start", 32'(sub_start), 0);
        cyc(1);
        check("rst_mid_after_pop", 32'(in_pop), 0);

        // Oversized OBU locks into the error state
        start_obu();
        hdr_done(4'd2, 32'(MAXW + 1), 0);
        check("big_err", 32'(err), 1);
        check("big_busy", 32'(busy), 1);
        in_valid = 1'b1;
        sub_pop  = 3'b111;
        enable   = 1'b1;
        n = 0;
        repeat (4) begin
            #1;
            if (in_pop) n++;
            cyc(1);
        end
        check("big_no_pop", 32'(n), 0);
        check("big_err_sticky", 32'(err), 1);
        rst     = 1'b1;
        enable  = 1'b0;
        sub_pop = 3'b000;
        cyc(1);
        rst = 1'b0;
        check("big_err_cleared", 32'(err), 0);

        // Done from a parser that does not own the stream
        start_obu();
        hdr_done(4'd1, 32'd4, 0);
        sub_done = 3'b100;
        cyc(1);
        sub_done = 3'b000;
        check("foreign_err", 32'(err), 1);
        check("foreign_grant", 32'(grant), 0);
        check("foreign_busy", 32'(busy), 1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;

        // OBU counter wrap
        m_count = 16'hFFFF;
        force dut.obu_cnt_q = 16'hFFFF;
        cyc(2);
        release dut.obu_cnt_q;
        check("pre_wrap", 32'(obu_count), 32'h0000_FFFF);
        start_obu();
        hdr_done(4'd5, 32'd0, 0);
        check("wrap", 32'(obu_count), 0);

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
